lcd_hd44780_responder: RTL and testbench

LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

---
 rtl/lcd_hd44780_responder_if.sv | 10 +
 rtl/lcd_hd44780_responder.sv | 153 +++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_hd44780_responder_if.sv
// HD44780 parallel bus as seen on the pins: the controller drives, the responder listens.
interface lcd_hd44780_responder_if;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_en;
  logic       lcd_rw;

  modport master (output lcd_data, output lcd_rs, output lcd_en, output lcd_rw);
  modport slave  (input  lcd_data, input  lcd_rs, input  lcd_en, input  lcd_rw);
endinterface

// File: rtl/lcd_hd44780_responder.sv
// Behavioural HD44780 responder: init FSM, 32-entry DDRAM, busy timing and readback port.
// Define LCD_TIMING_CHECK_EN to flag strobes that arrive while the display is still busy.
module lcd_hd44780_responder #(
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG  = 100000
) (
  input  logic                      clk_50MHz,
  input  logic                      reset_n,
  lcd_hd44780_responder_if.slave    lcd,
  input  logic [4:0]                rd_addr,
  output logic [7:0]                rd_char,
  output logic                      cmd_valid,
  output logic [7:0]                cmd_byte,
  output logic                      char_valid,
  output logic                      init_done,
  output logic                      display_on,
  output logic [4:0]                cursor,
  output logic                      busy,
  output logic                      timing_err
);

  localparam int CW = $clog2(BUSY_LONG + 1);

  typedef enum logic [2:0] {UNINIT, SEEN1, SEEN2, SEEN3, READY, CLEARING} state_t;

  state_t        state;
  logic [7:0]    ddram [32];
  logic [4:0]    clr_idx;
  logic          increment;
  logic [CW-1:0] busy_cnt;

  logic          en_s1, en_s2, en_s3;
  logic [7:0]    data_d1, data_d2;
  logic          rs_d1, rs_d2, rw_d1, rw_d2;

  logic          hold_valid, hold_rs;
  logic [7:0]    hold_data;

  logic          new_ev, ev_valid, ev_rs;
  logic [7:0]    ev_data;

  // Bus fields ride alongside the enable synchronizer so they line up with the strobe.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      en_s1 <= 1'b0; en_s2 <= 1'b0; en_s3 <= 1'b0;
      data_d1 <= 8'h00; data_d2 <= 8'h00;
      rs_d1 <= 1'b0; rs_d2 <= 1'b0; rw_d1 <= 1'b0; rw_d2 <= 1'b0;
    end else begin
      en_s1 <= lcd.lcd_en;   en_s2 <= en_s1;     en_s3 <= en_s2;
      data_d1 <= lcd.lcd_data; data_d2 <= data_d1;
      rs_d1 <= lcd.lcd_rs;   rs_d2 <= rs_d1;
      rw_d1 <= lcd.lcd_rw;   rw_d2 <= rw_d1;
    end
  end

  assign new_ev   = en_s3 & ~en_s2 & ~rw_d2;
  // A strobe held over from a clear sweep takes priority over a fresh one.
  assign ev_valid = (state != CLEARING) && (hold_valid || new_ev);
  assign ev_rs    = hold_valid ? hold_rs   : rs_d2;
  assign ev_data  = hold_valid ? hold_data : data_d2;

  assign busy      = (busy_cnt != '0);
  assign init_done = (state == READY) || (state == CLEARING);

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNINIT;
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      clr_idx    <= 5'd0;
      increment  <= 1'b1;
      busy_cnt   <= '0;
      cursor     <= 5'd0;
      display_on <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'h00;
      char_valid <= 1'b0;
      rd_char    <= 8'h20;
      hold_valid <= 1'b0;
      hold_rs    <= 1'b0;
      hold_data  <= 8'h00;
    end else begin
      cmd_valid  <= 1'b0;
      char_valid <= 1'b0;
      rd_char    <= ddram[rd_addr];
      if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);

      if (state == CLEARING) begin
        ddram[clr_idx] <= 8'h20;
        clr_idx        <= clr_idx + 5'd1;
        if (clr_idx == 5'd31) state <= READY;
        if (new_ev) begin
          hold_valid <= 1'b1;
          hold_rs    <= rs_d2;
          hold_data  <= data_d2;
        end
      end else begin
        if (hold_valid) begin
          hold_valid <= new_ev;
          hold_rs    <= rs_d2;
          hold_data  <= data_d2;
        end
        if (ev_valid) begin
          busy_cnt <= CW'(BUSY_SHORT);
          if (!ev_rs) begin
            cmd_valid <= 1'b1;
            cmd_byte  <= ev_data;
            case (state)
              UNINIT: if (ev_data == 8'h30) state <= SEEN1;
              SEEN1:  if (ev_data == 8'h30) state <= SEEN2;
              SEEN2:  if (ev_data == 8'h30) state <= SEEN3;
              SEEN3:  if (ev_data == 8'h38) state <= READY;
              READY: begin
                if (ev_data[7]) begin
                  cursor <= {ev_data[6], ev_data[3:0]};
                end else if (ev_data[6:4] == 3'b000) begin
                  if (ev_data[3]) begin
                    display_on <= ev_data[2];
                  end else if (ev_data[2]) begin
                    increment <= ev_data[1];
                  end else if (ev_data[1]) begin
                    cursor   <= 5'd0;
                    busy_cnt <= CW'(BUSY_LONG);
                  end else if (ev_data[0]) begin
                    state     <= CLEARING;
                    clr_idx   <= 5'd0;
                    cursor    <= 5'd0;
                    increment <= 1'b1;
                    busy_cnt  <= CW'(BUSY_LONG);
                  end
                end
              end
              default: ;
            endcase
          end else if (state == READY) begin
            ddram[cursor] <= ev_data;
            char_valid    <= 1'b1;
            cursor        <= increment ? cursor + 5'd1 : cursor - 5'd1;
          end
        end
      end
    end
  end

`ifdef LCD_TIMING_CHECK_EN
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n)                 timing_err <= 1'b0;
    else if (ev_valid && busy)    timing_err <= 1'b1;
  end
`else
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for lcd_hd44780_responder with shortened busy times.
module tb_lcd_hd44780_responder;
  localparam int BS = 40;
  localparam int BL = 200;

  logic       clk_50MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [4:0] rd_addr   = 5'd0;
  logic [7:0] rd_char, cmd_byte;
  logic       cmd_valid, char_valid, init_done, display_on, busy, timing_err;
  logic [4:0] cursor;

  int compared   = 0;
  int mismatched = 0;
  int cmd_k, char_k;
  logic init_k2, init_k3;

  always #10 clk_50MHz = ~clk_50MHz;

  lcd_hd44780_responder_if bus ();

  lcd_hd44780_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .lcd       (bus),
    .rd_addr   (rd_addr),
    .rd_char   (rd_char),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .char_valid(char_valid),
    .init_done (init_done),
    .display_on(display_on),
    .cursor    (cursor),
    .busy      (busy),
    .timing_err(timing_err)
  );

  // One enable pulse; records in which cycle after the falling edge each pulse appeared.
  task automatic send(input logic rs, input logic [7:0] data, input logic rw);
    @(posedge clk_50MHz); #1;
    bus.lcd_rs = rs; bus.lcd_data = data; bus.lcd_rw = rw; bus.lcd_en = 1'b1;
    repeat (3) @(posedge clk_50MHz);
    #1 bus.lcd_en = 1'b0;
    cmd_k = -1; char_k = -1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk_50MHz); @(negedge clk_50MHz);
      if (cmd_valid)  cmd_k  = k;
      if (char_valid) char_k = k;
      if (k == 2) init_k2 = init_done;
      if (k == 3) init_k3 = init_done;
    end
    bus.lcd_rw = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < BL + 100; i++) begin
      if (!busy) break;
      @(negedge clk_50MHz);
    end
    compared++;
    if (busy) begin mismatched++; $display("[TB] FAIL wait_idle: busy=%b required 0", busy); end
  endtask

  task automatic read_ddram(input logic [4:0] a, output logic [7:0] v);
    @(posedge clk_50MHz); #1 rd_addr = a;
    @(posedge clk_50MHz); @(negedge clk_50MHz);
    v = rd_char;
  endtask

  // Busy has been seen high on the last three samples inside send().
  task automatic busy_run(output int len);
    len = 3;
    for (int i = 0; i < BL + 100; i++) begin
      @(negedge clk_50MHz);
      if (!busy) break;
      len++;
    end
  endtask

  task automatic test_reset();
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data = 8'h00;
    reset_n = 1'b0;
    repeat (3) @(negedge clk_50MHz);
    compared++;
    if ({cmd_valid, char_valid, init_done, display_on, busy, timing_err} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got %b required 000000",
               {cmd_valid, char_valid, init_done, display_on, busy, timing_err});
    end
    compared++;
    if (rd_char !== 8'h20) begin mismatched++; $display("[TB] FAIL reset_rd_char: got %h required 20", rd_char); end
    compared++;
    if (cursor !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_cursor: got %0d required 0", cursor); end
    compared++;
    if (cmd_byte !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_cmd_byte: got %h required 00", cmd_byte); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_50MHz);
  endtask

  task automatic test_init();
    send(1'b0, 8'h08, 1'b0);
    compared++;
    if (cmd_k !== 3) begin mismatched++; $display("[TB] FAIL early_cmd_pulse: got cycle %0d required 3", cmd_k); end
    compared++;
    if (init_done !== 1'b0 || display_on !== 1'b0) begin
      mismatched++; $display("[TB] FAIL early_cmd_ignored: got init=%b disp=%b required 0 0", init_done, display_on);
    end
    wait_idle();
    for (int i = 0; i < 3; i++) begin send(1'b0, 8'h30, 1'b0); wait_idle(); end
    send(1'b1, 8'h41, 1'b0);
    compared++;
    if (char_k !== -1) begin mismatched++; $display("[TB] FAIL data_before_ready: got pulse cycle %0d required none", char_k); end
    wait_idle();
    send(1'b0, 8'h38, 1'b0);
    compared++;
    if ({init_k2, init_k3} !== 2'b01) begin
      mismatched++; $display("[TB] FAIL init_done_timing: got %b required 01", {init_k2, init_k3});
    end
    compared++;
    if (cmd_byte !== 8'h38 || cursor !== 5'd0) begin
      mismatched++; $display("[TB] FAIL init_state: got cmd=%h cursor=%0d required 38 0", cmd_byte, cursor);
    end
    wait_idle();
  endtask

  task automatic test_load();
    logic [7:0] v;
    logic [7:0] txt [4];
    txt[0] = 8'h4C; txt[1] = 8'h4F; txt[2] = 8'h41; txt[3] = 8'h44;
    send(1'b0, 8'h80, 1'b0); wait_idle();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, txt[i], 1'b0);
      compared++;
      if (char_k !== 3) begin mismatched++; $display("[TB] FAIL load_char_pulse%0d: got cycle %0d required 3", i, char_k); end
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      read_ddram(5'(i), v);
      compared++;
      if (v !== txt[i]) begin mismatched++; $display("[TB] FAIL load_read%0d: got %h required %h", i, v, txt[i]); end
    end
    compared++;
    if (cursor !== 5'd4) begin mismatched++; $display("[TB] FAIL load_cursor: got %0d required 4", cursor); end
    compared++;
    if (timing_err !== 1'b0) begin mismatched++; $display("[TB] FAIL load_timing_err: got %b required 0", timing_err); end
  endtask

  task automatic test_display();
    send(1'b0, 8'h0C, 1'b0); wait_idle();
    compared++;
    if (display_on !== 1'b1) begin mismatched++; $display("[TB] FAIL display_on: got %b required 1", display_on); end
    send(1'b0, 8'h08, 1'b0); wait_idle();
    compared++;
    if (display_on !== 1'b0) begin mismatched++; $display("[TB] FAIL display_off: got %b required 0", display_on); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    send(1'b0, 8'hCF, 1'b0); wait_idle();
    compared++;
    if (cursor !== 5'd31) begin mismatched++; $display("[TB] FAIL addr_cf: got %0d required 31", cursor); end
    send(1'b1, 8'h41, 1'b0); wait_idle();
    send(1'b1, 8'h42, 1'b0); wait_idle();
    read_ddram(5'd31, v);
    compared++;
    if (v !== 8'h41) begin mismatched++; $display("[TB] FAIL wrap_read31: got %h required 41", v); end
    read_ddram(5'd0, v);
    compared++;
    if (v !== 8'h42) begin mismatched++; $display("[TB] FAIL wrap_read0: got %h required 42", v); end
    compared++;
    if (cursor !== 5'd1) begin mismatched++; $display("[TB] FAIL wrap_cursor: got %0d required 1", cursor); end
  endtask

  task automatic test_decrement();
    logic [7:0] v;
    send(1'b0, 8'h04, 1'b0); wait_idle();
    send(1'b0, 8'h80, 1'b0); wait_idle();
    send(1'b1, 8'h58, 1'b0); wait_idle();
    compared++;
    if (cursor !== 5'd31) begin mismatched++; $display("[TB] FAIL dec_cursor: got %0d required 31", cursor); end
    read_ddram(5'd0, v);
    compared++;
    if (v !== 8'h58) begin mismatched++; $display("[TB] FAIL dec_read0: got %h required 58", v); end
    send(1'b0, 8'h06, 1'b0); wait_idle();
  endtask

  task automatic test_rw_ignored();
    send(1'b1, 8'h77, 1'b1);
    compared++;
    if (cmd_k !== -1 || char_k !== -1 || busy !== 1'b0 || cursor !== 5'd31) begin
      mismatched++;
      $display("[TB] FAIL rw_ignored: got cmd_k=%0d char_k=%0d busy=%b cursor=%0d required -1 -1 0 31",
               cmd_k, char_k, busy, cursor);
    end
  endtask

  task automatic test_home();
    logic [7:0] v;
    int len;
    send(1'b0, 8'h02, 1'b0);
    busy_run(len);
    compared++;
    if (len !== BL) begin mismatched++; $display("[TB] FAIL home_busy_len: got %0d required %0d", len, BL); end
    compared++;
    if (cursor !== 5'd0) begin mismatched++; $display("[TB] FAIL home_cursor: got %0d required 0", cursor); end
    read_ddram(5'd31, v);
    compared++;
    if (v !== 8'h41) begin mismatched++; $display("[TB] FAIL home_ddram_kept: got %h required 41", v); end
  endtask

  task automatic test_clear();
    logic [7:0] v;
    int len;
    int bad;
    send(1'b0, 8'h01, 1'b0);
    busy_run(len);
    compared++;
    if (len !== BL) begin mismatched++; $display("[TB] FAIL clear_busy_len: got %0d required %0d", len, BL); end
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      read_ddram(5'(i), v);
      if (v !== 8'h20) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("[TB] FAIL clear_ddram: got %0d non-blank entries required 0", bad); end
    compared++;
    if (cursor !== 5'd0) begin mismatched++; $display("[TB] FAIL clear_cursor: got %0d required 0", cursor); end
  endtask

  task automatic test_held_during_clear();
    logic [7:0] v;
    send(1'b1, 8'h33, 1'b0); wait_idle();
    send(1'b0, 8'h01, 1'b0);
    send(1'b1, 8'h5A, 1'b0);
    compared++;
    if (char_k !== -1) begin mismatched++; $display("[TB] FAIL held_no_early_pulse: got cycle %0d required none", char_k); end
    repeat (40) @(negedge clk_50MHz);
    wait_idle();
    read_ddram(5'd0, v);
    compared++;
    if (v !== 8'h5A) begin mismatched++; $display("[TB] FAIL held_read0: got %h required 5A", v); end
    read_ddram(5'd1, v);
    compared++;
    if (v !== 8'h20) begin mismatched++; $display("[TB] FAIL held_read1: got %h required 20", v); end
    compared++;
    if (cursor !== 5'd1) begin mismatched++; $display("[TB] FAIL held_cursor: got %0d required 1", cursor); end
  endtask

  task automatic test_back_to_back();
    logic exp_err;
`ifdef LCD_TIMING_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(1'b1, 8'h61, 1'b0);
    send(1'b1, 8'h62, 1'b0);
    compared++;
    if (char_k !== 3) begin mismatched++; $display("[TB] FAIL b2b_processed: got cycle %0d required 3", char_k); end
    compared++;
    if (timing_err !== exp_err) begin
      mismatched++; $display("[TB] FAIL timing_err: got %b required %b", timing_err, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_load();
    test_display();
    test_wrap();
    test_decrement();
    test_rw_ignored();
    test_home();
    test_clear();
    test_held_during_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
